// File: rtl/smart_cargo_pkg.sv
// Shared SmartCargo definitions: FSM state codes, request byte field positions
// and the helper that packs a request into its 6-bit payload.
package smart_cargo_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        START   = 4'd2,
        DADOS   = 4'd3,
        STOP    = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam int         ORIG_LSB    = 0;
    localparam int         DEST_LSB    = 2;
    localparam int         TIPO_LSB    = 4;
    localparam int         PEDIDO_W    = 6;
    localparam logic [1:0] TIPO_NENHUM = 2'b00;

    function automatic logic [PEDIDO_W-1:0] monta_pedido(input logic [1:0] tipo,
                                                         input logic [1:0] origem,
                                                         input logic [1:0] destino);
        logic [PEDIDO_W-1:0] v;
        v                  = '0;
        v[ORIG_LSB +: 2]   = origem;
        v[DEST_LSB +: 2]   = destino;
        v[TIPO_LSB +: 2]   = tipo;
        return v;
    endfunction

endpackage

// File: rtl/tx_pedidos_serial_8n1_if.sv
// Request handshake bundle between the operator panel (master) and the
// serial request transmitter (slave).
interface tx_pedidos_serial_8n1_if;
    logic       pedido_valido;
    logic       pedido_pronto;
    logic [1:0] tipo;
    logic [1:0] origem;
    logic [1:0] destino;
    logic       erro_pedido;

    modport master (output pedido_valido, tipo, origem, destino,
                    input  pedido_pronto, erro_pedido);
    modport slave  (input  pedido_valido, tipo, origem, destino,
                    output pedido_pronto, erro_pedido);
endinterface

// File: rtl/fifo_pedidos_sync.sv
// Small synchronous request FIFO (power-of-two depth) with empty/full flags.
// Push while full and pop while empty are ignored.
module fifo_pedidos_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vazia,
    output logic             cheia
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign vazia  = (r_count == '0);
    assign cheia  = (r_count == CW'(DEPTH));
    assign w_push = push & ~cheia;
    assign w_pop  = pop & ~vazia;
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/tx_pedidos_serial_8n1.sv
// SmartCargo request transmitter: validates requests, queues them and sends each as
// one 8N1 byte. Define STOP2_EN to send two stop bits per frame.
module tx_pedidos_serial_8n1
    import smart_cargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    tx_pedidos_serial_8n1_if.slave  pedido,
    output logic                    TX,
    output logic                    ocupado,
    output logic                    fila_vazia,
    output logic                    fila_cheia,
    output logic [3:0]              db_estado
);
    localparam int             TICK_W   = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_BIT - 1);
`ifdef STOP2_EN
    localparam logic [2:0]     STOP_ULT = 3'd1;
`else
    localparam logic [2:0]     STOP_ULT = 3'd0;
`endif

    estado_t             r_estado;
    estado_t             w_prox;
    logic [TICK_W-1:0]   r_tick;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_ocupado;
    logic                r_erro;
    logic                w_tx;
    logic                w_ocupado;
    logic                w_pop;
    logic                w_fim_bit;
    logic                w_valido;
    logic                w_aceite;
    logic                w_push;
    logic                w_vazia;
    logic                w_cheia;
    logic [PEDIDO_W-1:0] w_cabeca;

    assign w_valido = (pedido.tipo != TIPO_NENHUM) && (pedido.origem != pedido.destino);
    assign w_aceite = pedido.pedido_valido & ~w_cheia;
    assign w_push   = w_aceite & w_valido;
    assign w_fim_bit = (r_tick == TICK_MAX);

    assign pedido.pedido_pronto = ~w_cheia;
    assign pedido.erro_pedido   = r_erro;
    assign TX         = r_tx;
    assign ocupado    = r_ocupado;
    assign fila_vazia = w_vazia;
    assign fila_cheia = w_cheia;
    assign db_estado  = r_estado;

    fifo_pedidos_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PEDIDO_W)
    ) u_fila (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (monta_pedido(pedido.tipo, pedido.origem, pedido.destino)),
        .dout  (w_cabeca),
        .vazia (w_vazia),
        .cheia (w_cheia)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox    = r_estado;
        w_pop     = 1'b0;
        w_tx      = 1'b1;
        w_ocupado = 1'b0;
        case (r_estado)
            INICIAL: if (!w_vazia) w_prox = CARREGA;
            CARREGA: begin
                w_pop  = 1'b1;
                w_prox = START;
            end
            START: begin
                w_tx      = 1'b0;
                w_ocupado = 1'b1;
                if (w_fim_bit) w_prox = DADOS;
            end
            DADOS: begin
                w_tx      = r_shift[0];
                w_ocupado = 1'b1;
                if (w_fim_bit && r_bit == 3'd7) w_prox = STOP;
            end
            STOP: begin
                w_ocupado = 1'b1;
                if (w_fim_bit && r_bit == STOP_ULT) w_prox = FIM;
            end
            FIM:     w_prox = INICIAL;
            default: w_prox = INICIAL;
        endcase
    end

    // Line outputs are registered, so the line lags the state by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ocupado <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            r_tx      <= w_tx;
            r_ocupado <= w_ocupado;
            r_erro    <= w_aceite & ~w_valido;
            if (r_estado == CARREGA) begin
                r_shift <= {2'b00, w_cabeca};
                r_tick  <= '0;
                r_bit   <= '0;
            end else if (w_ocupado) begin
                r_tick <= w_fim_bit ? '0 : r_tick + 1'b1;
                if (w_fim_bit && r_estado != START) r_bit <= r_bit + 1'b1;
                if (w_fim_bit && r_estado == DADOS) r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_tx_pedidos_serial_8n1.sv
// Self-checking bench: frame-level reference model of the request transmitter
// compared every cycle, plus hand-computed literal checks.
module tb_tx_pedidos_serial_8n1;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef STOP2_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       TX;
    logic       ocupado;
    logic       fila_vazia;
    logic       fila_cheia;
    logic [3:0] db_estado;

    tx_pedidos_serial_8n1_if bus ();

    tx_pedidos_serial_8n1 #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .pedido     (bus),
        .TX         (TX),
        .ocupado    (ocupado),
        .fila_vazia (fila_vazia),
        .fila_cheia (fila_cheia),
        .db_estado  (db_estado)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted bytes plus the schedule of frames on the line.
    // cyc numbers the interval following each rising edge.
    int q[$];
    int cyc    = 0;
    int pend_s = -1;
    int fr_s   = -1000;
    int fr_b   = 0;
    int erro_c = -1;

    always @(posedge clk) begin
        int  sz;
        bit  acc;
        cyc++;
        if (rst) begin
            q.delete();
            pend_s = -1;
            fr_s   = -1000;
            erro_c = -1;
        end else begin
            sz  = q.size();
            acc = bus.pedido_valido && (sz < DEPTH);
            if (pend_s >= 0 && cyc == pend_s - 1) begin
                fr_s   = pend_s;
                fr_b   = q.pop_front();
                pend_s = -1;
            end
            if (acc) begin
                if (bus.tipo != 2'b00 && bus.origem != bus.destino)
                    q.push_back(int'(bus.tipo) * 16 + int'(bus.destino) * 4 + int'(bus.origem));
                else
                    erro_c = cyc;
            end
            if (pend_s < 0 && q.size() > 0)
                pend_s = (cyc + 3 > fr_s + F + 3) ? cyc + 3 : fr_s + F + 3;
        end
    end

    always @(negedge clk) begin
        int etx, eoc, est, idx, ph, c;
        if (!rst && chk_on) begin
            c   = cyc;
            etx = 1;
            eoc = 0;
            if (c >= fr_s && c < fr_s + F) begin
                idx = (c - fr_s) / CPB;
                eoc = 1;
                if (idx == 0)      etx = 0;
                else if (idx <= 8) etx = (fr_b >> (idx - 1)) & 1;
                else               etx = 1;
            end
            if (c >= fr_s - 1 && c <= fr_s + F - 2) begin
                ph  = (c + 1 - fr_s) / CPB;
                est = (ph == 0) ? 2 : (ph <= 8) ? 3 : 4;
            end else if (c == fr_s + F - 1) est = 5;
            else if (pend_s >= 0 && c == pend_s - 2) est = 1;
            else est = 0;
            chk("tx", int'(TX), etx);
            chk("ocupado", int'(ocupado), eoc);
            chk("estado", int'(db_estado), est);
            chk("erro", int'(bus.erro_pedido), (erro_c == c) ? 1 : 0);
            chk("vazia", int'(fila_vazia), (q.size() == 0) ? 1 : 0);
            chk("cheia", int'(fila_cheia), (q.size() == DEPTH) ? 1 : 0);
            chk("pronto", int'(bus.pedido_pronto), (q.size() < DEPTH) ? 1 : 0);
        end
    end

    task automatic send(input int t, input int o, input int d, output int k);
        bus.tipo          = 2'(t);
        bus.origem        = 2'(o);
        bus.destino       = 2'(d);
        bus.pedido_valido = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus.pedido_valido = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (!(q.size() == 0 && pend_s < 0 && cyc >= fr_s + F + 2) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: queue=%0d still pending after %0d cycles", q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k, k2, s, len, n;
        int exp_bits[10];
        exp_bits = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        bus.pedido_valido = 1'b0;
        bus.tipo    = 2'b00;
        bus.origem  = 2'b00;
        bus.destino = 2'b00;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", int'(TX), 1);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_erro", int'(bus.erro_pedido), 0);
        chk("rst_vazia", int'(fila_vazia), 1);
        chk("rst_cheia", int'(fila_cheia), 0);
        chk("rst_pronto", int'(bus.pedido_pronto), 1);
        chk("rst_estado", int'(db_estado), 0);
        @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // 1: byte 0x1C, fixed latency and bit pattern
        send(1, 0, 3, k);
        wait_cyc(k + 2);
        chk("t1_pre_start", int'(TX), 1);
        wait_cyc(k + 3);
        chk("t1_start_fall", int'(TX), 0);
        chk("t1_model_byte", fr_b, 'h1C);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(k + 3 + 4 * i + 1);
            chk("t1_bit", int'(TX), exp_bits[i]);
        end
        drain();

        // 2: no object -> error pulse, nothing queued
        send(0, 1, 2, k);
        chk("t2_erro", int'(bus.erro_pedido), 1);
        chk("t2_vazia", int'(fila_vazia), 1);
        @(negedge clk);
        chk("t2_erro_end", int'(bus.erro_pedido), 0);
        chk("t2_tx", int'(TX), 1);
        drain();

        // 3: same-floor request
        send(2, 2, 2, k);
        chk("t3_erro", int'(bus.erro_pedido), 1);
        chk("t3_vazia", int'(fila_vazia), 1);
        drain();

        // 4: six back-to-back requests while idle
        for (int i = 0; i < 6; i++) begin
            bus.tipo    = 2'(1 + i % 3);
            bus.origem  = 2'(i % 4);
            bus.destino = 2'((i + 1) % 4);
            bus.pedido_valido = 1'b1;
            @(posedge clk);
            #1 if (i == 0) k = cyc;
            @(negedge clk);
            if (i == 4) begin
                chk("t4_cheia", int'(fila_cheia), 1);
                chk("t4_pronto", int'(bus.pedido_pronto), 0);
                chk("t4_model_cnt", q.size(), 4);
            end
        end
        bus.pedido_valido = 1'b0;
        drain();

        // 5: reset during data bit 3 of byte 0x16 (bit 3 is 0)
        send(1, 2, 1, k);
        send(2, 0, 1, k2);
        s = k + 3;
        wait_cyc(s + 17);
        chk("t5_pre_tx", int'(TX), 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_tx", int'(TX), 1);
        chk("t5_ocupado", int'(ocupado), 0);
        chk("t5_vazia", int'(fila_vazia), 1);
        chk("t5_estado", int'(db_estado), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_idle_tx", int'(TX), 1);

        // 6: frame length for byte 0x2D
        send(2, 1, 3, k);
        n = 0;
        while (ocupado !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_model_byte", fr_b, 'h2D);
        len = 0;
        while (ocupado === 1'b1 && len < 100) begin
            @(negedge clk);
            len++;
        end
`ifdef STOP2_EN
        chk("t6_frame_len", len, 44);
`else
        chk("t6_frame_len", len, 40);
`endif
        drain();

        // random traffic against the model
        repeat (400) begin
            bus.pedido_valido = ($urandom_range(0, 2) != 0);
            bus.tipo    = 2'($urandom_range(0, 3));
            bus.origem  = 2'($urandom_range(0, 3));
            bus.destino = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.pedido_valido = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
